// File: rtl/scoreboard_status.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_status
// Description : Scoreboard status tracker for a small set of functional units
//               (FUs). Each FU walks IDLE -> READ -> EXEC -> WB. Operand
//               readiness (RAW), write-after-read holds (WAR) and the
//               per-register pending-writer map are maintained here.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               issue_*            - issue request (FU, Fi, Fj, Fk)
//               exec_done          - per-FU execution-complete pulse
//               fu_busy            - per-FU busy flag
//               reg_result_fu      - one-hot pending writer per register
//               read_grant         - per-FU operand-read pulse
//               wb_grant           - per-FU writeback pulse
//               fu_fi              - destination register held by each FU
//               issue_err          - pulse one cycle after issue to busy FU
// Revision    : 1.0 - initial release
// ============================================================================
module scoreboard_status #(
    parameter int NUM_FUS  = 4,
    parameter int NUM_REGS = 32,
    parameter int REG_BITS = 5,
    parameter int FU_BITS  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    input  logic [FU_BITS-1:0]          issue_fu,
    input  logic [REG_BITS-1:0]         issue_fi,
    input  logic [REG_BITS-1:0]         issue_fj,
    input  logic [REG_BITS-1:0]         issue_fk,
    input  logic [NUM_FUS-1:0]          exec_done,
    output logic [NUM_FUS-1:0]          fu_busy,
    output logic [NUM_REGS*NUM_FUS-1:0] reg_result_fu,
    output logic [NUM_FUS-1:0]          read_grant,
    output logic [NUM_FUS-1:0]          wb_grant,
    output logic [NUM_FUS*REG_BITS-1:0] fu_fi,
    output logic                        issue_err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_READ = 2'd1;
    localparam logic [1:0] c_EXEC = 2'd2;
    localparam logic [1:0] c_WB   = 2'd3;

    // Per-FU state
    logic [1:0]          r_state [NUM_FUS];
    logic [REG_BITS-1:0] r_fi    [NUM_FUS];
    logic [REG_BITS-1:0] r_fj    [NUM_FUS];
    logic [REG_BITS-1:0] r_fk    [NUM_FUS];
    logic [FU_BITS-1:0]  r_qj    [NUM_FUS];
    logic [FU_BITS-1:0]  r_qk    [NUM_FUS];
    logic [NUM_FUS-1:0]  r_rj;
    logic [NUM_FUS-1:0]  r_rk;

    logic [NUM_REGS*NUM_FUS-1:0] r_reg_result;
    logic                        r_issue_err;

    logic [NUM_FUS-1:0]          w_busy;
    logic [NUM_FUS-1:0]          w_read_grant;
    logic [NUM_FUS-1:0]          w_wb_grant;
    logic [NUM_FUS-1:0]          w_war_block;
    logic [NUM_FUS-1:0]          w_issue_sel;
    logic [NUM_FUS-1:0]          w_issue_go;
    logic                        w_issue_busy;
    logic [NUM_FUS-1:0]          w_field_j;
    logic [NUM_FUS-1:0]          w_field_k;
    logic                        w_rj_init;
    logic                        w_rk_init;
    logic [FU_BITS-1:0]          w_qj_init;
    logic [FU_BITS-1:0]          w_qk_init;
    logic [NUM_REGS*NUM_FUS-1:0] w_reg_result_nxt;

    function automatic logic [FU_BITS-1:0] f_oh2idx(input logic [NUM_FUS-1:0] oh);
        logic [FU_BITS-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_FUS; i++) begin
            if (oh[i]) idx = idx | FU_BITS'(i);
        end
        return idx;
    endfunction

    // Per-FU status decode
    generate
        for (genvar f = 0; f < NUM_FUS; f++) begin : g_fu_status
            assign w_busy[f]       = (r_state[f] != c_IDLE);
            assign w_read_grant[f] = (r_state[f] == c_READ) && r_rj[f] && r_rk[f];
            assign w_wb_grant[f]   = (r_state[f] == c_WB) && !w_war_block[f];
            assign w_issue_sel[f]  = issue_valid && (issue_fu == FU_BITS'(f));
            assign fu_fi[f*REG_BITS +: REG_BITS] = r_fi[f];
        end
    endgenerate

    assign w_issue_go   = w_issue_sel & ~w_busy;
    assign w_issue_busy = |(w_issue_sel & w_busy);

    // WAR hold: an FU may not write a register that a READ-stage FU still
    // has marked as a ready (not yet read) operand.
    always_comb begin
        w_war_block = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            for (int g = 0; g < NUM_FUS; g++) begin
                if ((g != f) && (r_state[g] == c_READ) &&
                    (((r_fj[g] == r_fi[f]) && r_rj[g]) ||
                     ((r_fk[g] == r_fi[f]) && r_rk[g]))) begin
                    w_war_block[f] = 1'b1;
                end
            end
        end
    end

    // Pending-writer lookup for the issuing sources. The loop starts at
    // register 1 so that register 0 always reads as having no writer.
    always_comb begin
        w_field_j = '0;
        w_field_k = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (issue_fj == REG_BITS'(r)) w_field_j = r_reg_result[r*NUM_FUS +: NUM_FUS];
            if (issue_fk == REG_BITS'(r)) w_field_k = r_reg_result[r*NUM_FUS +: NUM_FUS];
        end
    end

    // A source is ready if it has no writer, or its writer is writing back
    // in this very cycle (the field is one-hot, so masking is sufficient).
    assign w_rj_init = ((w_field_j & ~w_wb_grant) == '0);
    assign w_rk_init = ((w_field_k & ~w_wb_grant) == '0);
    assign w_qj_init = f_oh2idx(w_field_j);
    assign w_qk_init = f_oh2idx(w_field_k);

    // Pending-writer map update. Writeback clears only the writer's own bit,
    // so a newer writer of the same register is never wiped out. A
    // same-cycle issue to that register is applied last and therefore wins.
    always_comb begin
        w_reg_result_nxt = r_reg_result;
        for (int f = 0; f < NUM_FUS; f++) begin
            if (w_wb_grant[f]) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (r_fi[f] == REG_BITS'(r)) w_reg_result_nxt[r*NUM_FUS + f] = 1'b0;
                end
            end
        end
        if (w_issue_go != '0) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (issue_fi == REG_BITS'(r)) w_reg_result_nxt[r*NUM_FUS +: NUM_FUS] = w_issue_go;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < NUM_FUS; f++) begin
                r_state[f] <= c_IDLE;
                r_fi[f]    <= '0;
                r_fj[f]    <= '0;
                r_fk[f]    <= '0;
                r_qj[f]    <= '0;
                r_qk[f]    <= '0;
            end
            r_rj         <= '0;
            r_rk         <= '0;
            r_reg_result <= '0;
            r_issue_err  <= 1'b0;
        end else begin
            r_issue_err  <= w_issue_busy;
            r_reg_result <= w_reg_result_nxt;
            for (int f = 0; f < NUM_FUS; f++) begin
                case (r_state[f])
                    c_IDLE: begin
                        if (w_issue_go[f]) begin
                            r_state[f] <= c_READ;
                            r_fi[f]    <= issue_fi;
                            r_fj[f]    <= issue_fj;
                            r_fk[f]    <= issue_fk;
                            r_qj[f]    <= w_qj_init;
                            r_qk[f]    <= w_qk_init;
                            r_rj[f]    <= w_rj_init;
                            r_rk[f]    <= w_rk_init;
                        end
                    end
                    c_READ: begin
                        if (w_read_grant[f]) begin
                            r_state[f] <= c_EXEC;
                            r_rj[f]    <= 1'b0;
                            r_rk[f]    <= 1'b0;
                        end else begin
                            // Wake waiting operands when their producer writes back
                            if (!r_rj[f] && w_wb_grant[r_qj[f]]) r_rj[f] <= 1'b1;
                            if (!r_rk[f] && w_wb_grant[r_qk[f]]) r_rk[f] <= 1'b1;
                        end
                    end
                    c_EXEC: begin
                        if (exec_done[f]) r_state[f] <= c_WB;
                    end
                    default: begin
                        if (w_wb_grant[f]) r_state[f] <= c_IDLE;
                    end
                endcase
            end
        end
    end

    assign fu_busy       = w_busy;
    assign read_grant    = w_read_grant;
    assign wb_grant      = w_wb_grant;
    assign reg_result_fu = r_reg_result;
    assign issue_err     = r_issue_err;

endmodule
`default_nettype wire
